// File: rtl/rformat_pkg.sv
// Shared constants and types for the R-format sequencer: opcode/funct encodings,
// the instruction field layout and the sequencer state enum.
package rformat_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } rinstr_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_RS,
        RD_RT,
        EXEC,
        WB,
        DONE
    } state_t;

endpackage

// File: rtl/rformat_alu.sv
// Combinational R-format ALU. SLT (funct 0x2A) exists only when RFORMAT_SLT_EN is
// defined; otherwise that funct reports legal=0 like any other unsupported code.
module rformat_alu
    import rformat_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [5:0]        funct,
    output logic [DATA_W-1:0] y,
    output logic              legal
);

    always_comb begin
        y     = '0;
        legal = 1'b1;
        case (funct)
            FN_ADD: y = a + b;
            FN_SUB: y = a - b;
            FN_AND: y = a & b;
            FN_OR:  y = a | b;
`ifdef RFORMAT_SLT_EN
            FN_SLT: y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
`endif
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/rformat_seq.sv
// Multi-cycle R-format sequencer over a single-port register file:
// read rs, read rt, execute, write rd, done. Optional SLT via RFORMAT_SLT_EN.
module rformat_seq
    import rformat_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int AW     = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic [AW-1:0]     rf_addr,
    output logic              rf_we,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              illegal
);

    state_t              state, state_nx;
    rinstr_t             ir;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   alu_y;
    logic                alu_legal;
    logic                exec_ill;
    logic                armed;
    logic                unused_shamt;

    assign unused_shamt = ^ir.shamt;

    // Operand B is taken straight off rf_rdata during EXEC.
    rformat_alu #(.DATA_W(DATA_W)) u_alu (
        .a     (op_a),
        .b     (rf_rdata),
        .funct (ir.funct),
        .y     (alu_y),
        .legal (alu_legal)
    );

    assign exec_ill = (ir.opcode != OP_RTYPE) || !alu_legal;

    // armed keeps instr_ready low while reset is held and until the first edge after release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            armed   <= 1'b0;
            ir      <= '0;
            op_a    <= '0;
            result  <= '0;
            illegal <= 1'b0;
        end else begin
            state <= state_nx;
            armed <= 1'b1;
            if (instr_ready && instr_valid) ir <= rinstr_t'(instr);
            if (state == RD_RT) op_a <= rf_rdata;
            if (state == EXEC) begin
                illegal <= exec_ill;
                if (!exec_ill) result <= alu_y;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        instr_ready = 1'b0;
        rf_addr     = '0;
        rf_we       = 1'b0;
        rf_wdata    = '0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = armed;
                if (armed && instr_valid) state_nx = RD_RS;
            end
            RD_RS: begin
                rf_addr  = AW'(ir.rs);
                state_nx = RD_RT;
            end
            RD_RT: begin
                rf_addr  = AW'(ir.rt);
                state_nx = EXEC;
            end
            EXEC: state_nx = WB;
            WB: begin
                // $0 is read-only and illegal instructions never write.
                rf_addr  = AW'(ir.rd);
                rf_wdata = result;
                rf_we    = !illegal && (ir.rd != 5'd0);
                state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rformat_seq.sv
// Scoreboard bench for rformat_seq: a behavioural register file answers the DUT,
// a reference model queues expected writes/completions, a monitor checks them.
module tb_rformat_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic [4:0]  rf_addr;
    logic        rf_we;
    logic [31:0] rf_wdata;
    logic [31:0] rf_rdata = '0;
    logic        done;
    logic [31:0] result;
    logic        illegal;

    rformat_seq #(.DATA_W(32), .AW(5)) dut (
        .clock       (clock),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rf_addr     (rf_addr),
        .rf_we       (rf_we),
        .rf_wdata    (rf_wdata),
        .rf_rdata    (rf_rdata),
        .done        (done),
        .result      (result),
        .illegal     (illegal)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Register file seen by the DUT, with a preload port for the bench.
    logic [31:0] rf [32];
    logic        pre_we = 1'b0;
    logic [4:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    initial for (int i = 0; i < 32; i++) rf[i] = '0;

    always @(posedge clock) begin
        if (pre_we) rf[pre_addr] <= pre_data;
        else if (rf_we) rf[rf_addr] <= rf_wdata;
        rf_rdata <= rf[rf_addr];
    end

    // Reference state
    logic [31:0] ref_rf [32];
    logic [31:0] ref_res = '0;
    initial for (int i = 0; i < 32; i++) ref_rf[i] = '0;

    typedef struct {
        int          acc;
        bit          has_wr;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] res;
        bit          ill;
    } exp_t;
    exp_t q[$];

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op, input int rs, input int rt,
                                       input int rd, input logic [5:0] fn);
        mk = {op, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    // Architectural effect of one instruction, computed from its encoding.
    function automatic exp_t model(input logic [31:0] w, input int acc);
        exp_t        e;
        logic [31:0] a, b, y;
        bit          ok;
        int          rd;
        a  = ref_rf[w[25:21]];
        b  = ref_rf[w[20:16]];
        rd = int'(w[15:11]);
        y  = '0;
        ok = (w[31:26] == 6'h00);
        case (w[5:0])
            6'h20: y = a + b;
            6'h22: y = a - b;
            6'h24: y = a & b;
            6'h25: y = a | b;
`ifdef RFORMAT_SLT_EN
            6'h2A: y = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
`endif
            default: ok = 0;
        endcase
        if (ok) begin
            ref_res = y;
            if (rd != 0) ref_rf[rd] = y;
        end
        e.acc    = acc;
        e.has_wr = ok && (rd != 0);
        e.wa     = 5'(rd);
        e.wd     = y;
        e.res    = ref_res;
        e.ill    = !ok;
        return e;
    endfunction

    // Monitor
    bit wr_seen = 0;
    always @(negedge clock) begin
        exp_t e;
        if (!reset) wr_seen = 0;
        else begin
            if (rf_we) begin
                if (q.size() == 0) chk("spurious_we", rf_we, 1'b0);
                else begin
                    chk("we_expected", q[0].has_wr, 1'b1);
                    chk("we_cycle", cyc - q[0].acc + 1, 4);
                    chk("we_addr", rf_addr, q[0].wa);
                    chk("we_data", rf_wdata, q[0].wd);
                    wr_seen = 1;
                end
            end
            if (done) begin
                if (q.size() == 0) chk("spurious_done", done, 1'b0);
                else begin
                    e = q.pop_front();
                    chk("done_latency", cyc - e.acc + 1, 5);
                    chk("result", result, e.res);
                    chk("illegal", illegal, e.ill);
                    chk("write_count", wr_seen, e.has_wr);
                    wr_seen = 0;
                end
            end
        end
    end

    task automatic preload(input int r, input logic [31:0] v);
        @(negedge clock);
        pre_we = 1'b1; pre_addr = 5'(r); pre_data = v;
        ref_rf[r] = v;
        @(negedge clock);
        pre_we = 1'b0;
    endtask

    // Offers w until accepted; returns the acceptance cycle. With junk set,
    // valid stays high with garbage while the sequencer is busy.
    task automatic issue(input logic [31:0] w, input bit junk, input bit track, output int acc);
        int n = 0;
        @(negedge clock);
        instr_valid = 1'b1; instr = w;
        while (!instr_ready && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (n >= 40) begin
            chk("accept_timeout", instr_ready, 1'b1);
            instr_valid = 1'b0;
            acc = cyc;
            return;
        end
        acc = cyc + 1;
        if (track) q.push_back(model(w, acc));
        @(posedge clock);
        #1;
        if (junk) begin
            for (int k = 0; k < 3; k++) begin
                instr = $urandom();
                @(negedge clock);
            end
        end
        instr_valid = 1'b0;
        instr = $urandom();
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("drain_pending", q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, instr_ready, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_we"}, rf_we, 1'b0);
        chk({tag, "_addr"}, rf_addr, 5'd0);
        chk({tag, "_wdata"}, rf_wdata, 32'd0);
        chk({tag, "_result"}, result, 32'd0);
        chk({tag, "_illegal"}, illegal, 1'b0);
    endtask

    logic [5:0] fn_tab [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};

    initial begin
        int a0, a1, a2, a3, ax;
        logic [5:0] op, fn;
        repeat (3) @(negedge clock);
        check_reset_outputs("rst");
        reset = 1'b1;
        #1 chk("ready_before_edge", instr_ready, 1'b0);
        @(negedge clock);
        chk("ready_after_reset", instr_ready, 1'b1);

        preload(1, 32'd212);
        preload(2, 32'd32);

        issue(mk(6'h00, 1, 2, 3, 6'h20), 1, 1, a0);
        issue(mk(6'h00, 2, 1, 4, 6'h22), 1, 1, a1);
        issue(mk(6'h00, 1, 2, 5, 6'h24), 0, 1, a2);
        issue(mk(6'h00, 1, 2, 6, 6'h25), 1, 1, a3);
        chk("issue_gap_sub", a1 - a0, 6);
        chk("issue_gap_and", a2 - a1, 6);
        chk("issue_gap_or", a3 - a2, 6);
        drain();
        chk("r4_wrap", rf[4], 32'hFFFFFF4C);

        issue(mk(6'h00, 1, 2, 0, 6'h20), 1, 1, ax);
        issue(mk(6'h00, 1, 2, 7, 6'h00), 1, 1, ax);
        issue(mk(6'h08, 1, 2, 7, 6'h20), 1, 1, ax);
        drain();

        preload(7, 32'hFFFFFFFB);
        preload(8, 32'd3);
        issue(mk(6'h00, 7, 8, 9, 6'h2A), 1, 1, ax);
        drain();

        // Abort during EXEC: no write to r10 may ever appear.
        issue(mk(6'h00, 1, 2, 10, 6'h20), 0, 0, ax);
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1 check_reset_outputs("abort");
        ref_res = '0;
        repeat (3) @(negedge clock);
        chk("abort_no_write", rf[10], ref_rf[10]);
        reset = 1'b1;
        @(negedge clock);
        chk("ready_after_abort", instr_ready, 1'b1);
        issue(mk(6'h00, 1, 2, 10, 6'h20), 1, 1, ax);
        drain();
        chk("r10_after_reset", rf[10], 32'd244);

        for (int r = 1; r < 32; r++) preload(r, $urandom());
        for (int i = 0; i < 60; i++) begin
            fn = fn_tab[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) fn = 6'($urandom());
            op = 6'h00;
            if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(1, 63));
            issue(mk(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                     int'($urandom_range(0, 31)), fn), 1'($urandom()), 1, ax);
            if ($urandom_range(0, 3) == 0) drain();
        end
        drain();
        repeat (3) @(negedge clock);
        for (int r = 0; r < 32; r++) chk($sformatf("final_r%0d", r), rf[r], ref_rf[r]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
